score_display_ctrl: RTL and testbench

Sequences conversion of the 13-bit reaction-time score into four BCD digits for the seven-segment display path. Uses an iterative shift-add-3 (double-dabble) engine over WIDTH cycles, replacing combinational divide-by-10 chains. Holds the resulting digits and drives per-digit enables for the downstream seven-segment decoders, with leading-zero blanking and an optional blink mode. Sits between the game FSM (score producer) and the seven-segment decoders.

---
 rtl/score_display_ctrl_pkg.sv | 16 +
 rtl/score_display_ctrl_bcd_add3_nibble.sv | 13 +
 rtl/score_display_ctrl.sv | 125 ++++++++++++
 tb/tb_score_display_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/score_display_ctrl_pkg.sv
// Shared defaults and encodings for the score display controller.
package score_display_ctrl_pkg;

    localparam int unsigned WIDTH_DEF  = 13;
    localparam int unsigned DIGITS_DEF = 4;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

endpackage

// File: rtl/score_display_ctrl_bcd_add3_nibble.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5 or more.
module bcd_add3_nibble
    import score_display_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = (nibble >= BCD_ADJ_THRESH) ? nibble + BCD_ADJ_ADD : nibble;
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Iterative binary-to-BCD conversion of the score, with digit hold,
// leading-zero blanking and blink gating of the per-digit decoder enables.
module score_display_ctrl
    import score_display_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned DIGITS    = DIGITS_DEF,
    parameter int unsigned BLINK_DIV = 12500000,
    parameter bit          LZ_BLANK  = 1'b1
) (
    input  logic              Clock,
    input  logic              CLRN,
    input  logic              Start,
    input  logic [WIDTH-1:0]  Value,
    input  logic              Display,
    input  logic              Blink,
    output logic              Busy,
    output logic              Done,
    output logic [3:0]        Digit1,
    output logic [3:0]        Digit2,
    output logic [3:0]        Digit3,
    output logic [3:0]        Digit4,
    output logic [DIGITS-1:0] DigitEn
);

    localparam int unsigned CNT_W   = $clog2(WIDTH + 1);
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    state_t                   state;
    logic [WIDTH-1:0]         shift_reg;
    logic [DIGITS-1:0][3:0]   bcd;
    logic [DIGITS-1:0][3:0]   adj;
    logic [DIGITS-1:0][3:0]   digit_q;
    logic [CNT_W-1:0]         bit_cnt;
    logic [BLINK_W-1:0]       blink_cnt;
    logic                     phase;
    logic [DIGITS-1:0]        visible;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3_nibble u_adj (
            .nibble   (bcd[g]),
            .adjusted (adj[g])
        );
    end

    always_ff @(posedge Clock) begin
        if (!CLRN) begin
            state     <= IDLE;
            shift_reg <= '0;
            bcd       <= '0;
            bit_cnt   <= '0;
            digit_q   <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        shift_reg <= Value;
                        bcd       <= '0;
                        bit_cnt   <= '0;
                        Busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, shift_reg} <= {adj, shift_reg} << 1;
                    bit_cnt          <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(WIDTH - 1))
                        state <= LOAD;
                end
                LOAD: begin
                    digit_q <= bcd;
                    Done    <= 1'b1;
                    Busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!CLRN) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (Blink) begin
            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end else begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end
    end

    // A digit is visible when it or any more significant digit is non-zero.
    always_comb begin
        visible = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            logic any_nz;
            any_nz = 1'b0;
            for (int unsigned j = i; j < DIGITS; j++)
                any_nz = any_nz | (digit_q[j] != 4'd0);
            visible[i] = (i == 0) || any_nz || !LZ_BLANK;
        end
    end

    always_ff @(posedge Clock) begin
        if (!CLRN)
            DigitEn <= '0;
        else
            DigitEn <= {DIGITS{Display & phase}} & visible;
    end

    assign Digit1 = digit_q[0];
    assign Digit2 = digit_q[1];
    assign Digit3 = digit_q[2];
    assign Digit4 = digit_q[3];

endmodule

// File: tb/tb_score_display_ctrl.sv
// Randomised and directed bench for score_display_ctrl against a
// number-level model (decimal arithmetic, latency countdown, blink edge count).
module tb_score_display_ctrl;

    localparam int unsigned WIDTH = 13;
    localparam int unsigned BD    = 4;
    localparam int unsigned LAT   = WIDTH + 1;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        start = 1'b0;
    logic [12:0] value = '0;
    logic        display = 1'b1;
    logic        blink = 1'b0;

    logic        busy_a, done_a, busy_b, done_b;
    logic [3:0]  d1_a, d2_a, d3_a, d4_a, d1_b, d2_b, d3_b, d4_b;
    logic [3:0]  en_a, en_b;

    int vectors = 0;
    int miscompares = 0;

    // model state
    int m_left = 0;
    int m_val = 0;
    int m_num = 0;
    int m_done = 0;
    int m_bedges = 0;
    logic [3:0] m_en_a = '0;
    logic [3:0] m_en_b = '0;

    always #5 clk = ~clk;

    score_display_ctrl #(.WIDTH(13), .DIGITS(4), .BLINK_DIV(BD), .LZ_BLANK(1'b1)) dut_a (
        .Clock(clk), .CLRN(clrn), .Start(start), .Value(value), .Display(display), .Blink(blink),
        .Busy(busy_a), .Done(done_a), .Digit1(d1_a), .Digit2(d2_a), .Digit3(d3_a), .Digit4(d4_a),
        .DigitEn(en_a)
    );

    score_display_ctrl #(.WIDTH(13), .DIGITS(4), .BLINK_DIV(BD), .LZ_BLANK(1'b0)) dut_b (
        .Clock(clk), .CLRN(clrn), .Start(start), .Value(value), .Display(display), .Blink(blink),
        .Busy(busy_b), .Done(done_b), .Digit1(d1_b), .Digit2(d2_b), .Digit3(d3_b), .Digit4(d4_b),
        .DigitEn(en_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'((n / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [3:0] lz_mask(input int n);
        logic [3:0] r = '0;
        for (int i = 0; i < 4; i++) r[i] = (i == 0) || (n >= pow10(i));
        return r;
    endfunction

    task automatic step();
        bit ph;
        @(posedge clk);
        #1;
        if (!clrn) begin
            m_left = 0; m_done = 0; m_num = 0; m_bedges = 0;
            m_en_a = '0; m_en_b = '0;
        end else begin
            ph = ((m_bedges / BD) % 2) == 0;
            m_en_a = (display && ph) ? lz_mask(m_num) : 4'h0;
            m_en_b = (display && ph) ? 4'hF : 4'h0;
            m_done = 0;
            if (m_left == 0) begin
                if (start) begin
                    m_left = LAT;
                    m_val  = int'(value);
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_num  = m_val;
                    m_done = 1;
                end
            end
            m_bedges = blink ? m_bedges + 1 : 0;
        end
        check("busy", 32'(busy_a), 32'(m_left > 0));
        check("done", 32'(done_a), 32'(m_done));
        check("digits", {16'h0, d4_a, d3_a, d2_a, d1_a}, {16'h0, to_bcd(m_num)});
        check("en_lz", 32'(en_a), 32'(m_en_a));
        check("en_all", 32'(en_b), 32'(m_en_b));
        check("digits_b", {16'h0, d4_b, d3_b, d2_b, d1_b}, {16'h0, to_bcd(m_num)});
    endtask

    task automatic convert(input int v);
        value = 13'(v);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40 && m_done == 0; i++) step();
        check("conv_done_seen", 32'(m_done), 32'd1);
    endtask

    initial begin
        // reset and idle display
        clrn = 1'b0;
        repeat (2) step();
        clrn = 1'b1;
        repeat (2) step();
        check("rst_en", 32'(en_a), 32'h1);
        check("rst_busy", 32'(busy_a), 32'h0);

        // 1234: busy/done timing is tracked by the model each cycle
        convert(1234);
        check("d1234", {16'h0, d4_a, d3_a, d2_a, d1_a}, 32'h1234);
        step();
        check("en1234", 32'(en_a), 32'hF);

        // 8191 with an ignored mid-conversion Start, then 7 started in the Done cycle
        value = 13'd8191;
        start = 1'b1;
        step();
        value = 13'd2;
        repeat (5) step();
        start = 1'b0;
        for (int i = 0; i < 40 && m_done == 0; i++) step();
        check("d8191", {16'h0, d4_a, d3_a, d2_a, d1_a}, 32'h8191);
        convert(7);
        step();
        check("d7", {16'h0, d4_a, d3_a, d2_a, d1_a}, 32'h0007);
        check("en7", 32'(en_a), 32'h1);

        // reset during SHIFT of 4321
        value = 13'd4321;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        clrn = 1'b0;
        step();
        clrn = 1'b1;
        check("abort_busy", 32'(busy_a), 32'h0);
        check("abort_dig", {16'h0, d4_a, d3_a, d2_a, d1_a}, 32'h0);
        repeat (16) step();

        // blink on 50
        convert(50);
        blink = 1'b1;
        repeat (20) step();
        blink = 1'b0;
        repeat (3) step();
        check("blink_off_en", 32'(en_a), 32'h3);

        // Display drop with all digits shown
        convert(5);
        repeat (2) step();
        check("en_all_on", 32'(en_b), 32'hF);
        display = 1'b0;
        step();
        check("en_all_off", 32'(en_b), 32'h0);
        check("d5_held", {16'h0, d4_b, d3_b, d2_b, d1_b}, 32'h0005);
        display = 1'b1;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: value = 13'($urandom_range(0, 9));
                1: value = 13'($urandom_range(0, 99));
                2: value = 13'($urandom_range(0, 999));
                default: value = 13'($urandom_range(0, 8191));
            endcase
            if ($urandom_range(0, 19) == 0) display = ~display;
            if ($urandom_range(0, 29) == 0) blink = ~blink;
            clrn = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
